// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: controller state
// encoding, default operand width and the bit-counter width rule.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold the value w itself, hence w+1 codes.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    // Borrow when b exceeds a, or when the bits are equal and a borrow ripples in.
    always_comb begin
        d_o    = a_i ^ b_i ^ bin_i;
        bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: captures a, b and bin on start, processes one bit
// per clock LSB first through a single full subtractor, then presents
// diff/bout with a one-cycle done pulse.
//
// Handshake: start is sampled only while idle (busy=0); the operands are
// captured on that same edge. done is a single-cycle pulse marking the
// first cycle in which diff/bout carry the new result; those outputs then
// hold until the next done. There is no back-pressure.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output state_t           state_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_d;
    logic             bit_bout;

    full_subtractor u_fs (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (br_q),
        .d_o    (bit_d),
        .bout_o (bit_bout)
    );

    // State and datapath registers; reset clears everything so no partial result survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update: capture in IDLE, one bit per edge in SHIFT.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the LSB-first stream lands in order.
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = {bit_d, res_q[WIDTH-1:1]};
                br_d  = bit_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Publish the completed word including the bit processed on this edge.
                    diff_d  = {bit_d, res_q[WIDTH-1:1]};
                    bout_d  = bit_bout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decoded directly from the state register.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        diff    = diff_q;
        bout    = bout_q;
        state_o = state_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor (WIDTH=4) against an
// arithmetic reference: diff = (a - b - bin) mod 16, bout = (a < b + bin).
module tb_serial_subtractor;
    import arith_pkg::*;

    localparam int W      = 4;
    localparam int MASK   = (1 << W) - 1;
    localparam int PERIOD = W + 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;
    state_t       state_o;

    int n_checks = 0;
    int n_fails  = 0;

    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;

    logic [W:0]   exp_q[$];
    logic [W:0]   exp_item;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .diff    (diff),
        .bout    (bout),
        .busy    (busy),
        .done    (done),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result packed as {borrow, diff}.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        int d;
        d = int'(x) - int'(y) - int'(z);
        return {(d < 0), W'(d & MASK)};
    endfunction

    // One complete operation: start for one edge, inputs scrambled while running.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        logic [W:0] exp;
        int         lat;
        exp   = ref_sub(ia, ib, ibin);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        tick();
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        lat = 0;
        while (!done && lat < 2 * W + 4) begin
            check("diff_hold", diff, last_diff);
            check("bout_hold", bout, last_bout);
            a     = W'($urandom_range(0, MASK));
            b     = W'($urandom_range(0, MASK));
            bin   = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency", lat, W);
        check("done_busy", busy, 1);
        check("diff", diff, exp[W-1:0]);
        check("bout", bout, exp[W]);
        last_diff = exp[W-1:0];
        last_bout = exp[W];
        tick();
        check("done_one_cycle", done, 0);
        check("idle_busy", busy, 0);
        check("diff_after_done", diff, last_diff);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        tick();
        tick();
        rst_n = 1'b1;

        // First start right after reset release, plus the directed corner cases.
        run_op(4'd9, 4'd3, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        check("dir_3m9_diff", diff, 10);
        check("dir_3m9_bout", bout, 1);
        run_op(4'd0, 4'd0, 1'b1);
        check("dir_0m0b_diff", diff, 15);
        run_op(4'd15, 4'd15, 1'b0);
        check("dir_15m15_diff", diff, 0);

        // start held high: one op every W+2 edges, operands churning every cycle.
        start = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            ra   = W'($urandom_range(0, MASK));
            rb   = W'($urandom_range(0, MASK));
            rbin = 1'($urandom_range(0, 1));
            a    = ra;
            b    = rb;
            bin  = rbin;
            if (i % PERIOD == 0) exp_q.push_back(ref_sub(ra, rb, rbin));
            tick();
            check("held_done", done, (i % PERIOD) == W);
            if ((i % PERIOD) == W && exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("held_diff", diff, exp_item[W-1:0]);
                check("held_bout", bout, exp_item[W]);
                last_diff = exp_item[W-1:0];
                last_bout = exp_item[W];
            end
        end
        start = 1'b0;
        check("held_queue_empty", exp_q.size(), 0);

        // Reset in the middle of 12-5, at bit 2.
        a     = 4'd12;
        b     = 4'd5;
        bin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_diff", diff, 0);
        check("midrst_bout", bout, 0);
        check("midrst_done", done, 0);
        check("midrst_state", 32'(state_o), 32'(IDLE));
        #2;
        rst_n     = 1'b1;
        last_diff = '0;
        last_bout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postrst_done", done, 0);
            check("postrst_busy", busy, 0);
            check("postrst_diff", diff, 0);
        end
        run_op(4'd12, 4'd5, 1'b0);
        check("rerun_12m5", diff, 7);

        // Exhaustive sweep of every operand combination.
        for (int x = 0; x <= MASK; x++)
            for (int y = 0; y <= MASK; y++)
                for (int z = 0; z < 2; z++)
                    run_op(W'(x), W'(y), 1'(z));

        // A few random operations in arbitrary order.
        for (int i = 0; i < 20; i++)
            run_op(W'($urandom_range(0, MASK)), W'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin one subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit, the borrow-in.
REQ-008 The block SHALL have port diff, output, WIDTH bits, the result of a - b - bin modulo 2^WIDTH.
REQ-009 The block SHALL have port bout, output, 1 bit, the final borrow-out.
REQ-010 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse when diff and bout are valid.

Function
REQ-012 The block SHALL implement an FSM with exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture a, b and bin into internal registers, clear the bit counter, and go to SHIFT on that edge.
REQ-014 In IDLE with start=0, the block SHALL hold all registers, including the previous diff and bout.
REQ-015 In SHIFT, each edge SHALL process the LSB of the operand shift registers: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-016 In SHIFT, each processed bit d SHALL be shifted into the result register MSB-first-in, so that after WIDTH bits the LSB-first stream forms diff, and the counter SHALL increment.
REQ-017 After the WIDTH-th bit edge, the block SHALL go to DONE, load diff from the result register and load bout from the borrow flip-flop.
REQ-018 Latency: with start sampled at edge k, done SHALL be high during the cycle after edge k+WIDTH and SHALL return to IDLE at edge k+WIDTH+1.
REQ-019 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-020 done SHALL be 1 only in DONE.
REQ-021 start SHALL be ignored in SHIFT and DONE; back-to-back operations need start=1 in IDLE, so the minimum spacing is WIDTH+2 cycles.
REQ-022 Changes on a, b and bin after capture SHALL NOT affect the operation in progress.
REQ-023 diff and bout SHALL change only on entry to DONE and SHALL hold until the next DONE.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE and set diff=0, bout=0, busy=0, done=0, the counter to 0, and all shift and borrow registers to 0.
REQ-025 An assertion of rst_n mid-operation SHALL abort the operation with no done pulse and no partial result visible on diff.
REQ-026 After rst_n deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-027 State encoding, WIDTH default and the counter width ($clog2(WIDTH+1)) SHALL live in a shared package arith_pkg.
REQ-028 The per-bit logic SHALL be a combinational sub-module full_subtractor (a, b, bin -> d, bout), instantiated once.

Verification
REQ-029 The bench SHALL cover WIDTH=4, a=9, b=3, bin=0, start one cycle -> done at cycle 5 after start, diff=6, bout=0.
REQ-030 The bench SHALL cover WIDTH=4, a=3, b=9, bin=0 -> diff=10 (1010), bout=1.
REQ-031 The bench SHALL cover WIDTH=4, a=0, b=0, bin=1 -> diff=15, bout=1; and a=15, b=15, bin=0 -> diff=0, bout=0.
REQ-032 The bench SHALL cover start held high continuously -> operations spaced exactly WIDTH+2 cycles, one done pulse each, with operands changed mid-operation having no effect.
REQ-033 The bench SHALL cover rst_n pulsed low at bit 2 of a=12-b=5 -> busy=0 and diff=0 immediately, no done; a new 12-5 then gives diff=7.
REQ-034 The bench SHALL run an exhaustive sweep of all a, b, bin for WIDTH=4 against a reference model computing (a-b-bin) mod 16 and the borrow.
